// File: rtl/fft_butterfly_pipe.sv
// Three-stage radix-2 DIT butterfly: sum = even + odd*W, diff = even - odd*W.
// Rounds the twiddle product, optionally halves, saturates, and flags overflow.
module fft_butterfly_pipe #(
    parameter int DATA_WIDTH    = 16,
    parameter int TWIDDLE_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    even_real,
    input  logic [DATA_WIDTH-1:0]    even_imag,
    input  logic [DATA_WIDTH-1:0]    odd_real,
    input  logic [DATA_WIDTH-1:0]    odd_imag,
    input  logic [TWIDDLE_WIDTH-1:0] twiddle_real,
    input  logic [TWIDDLE_WIDTH-1:0] twiddle_imag,
    input  logic                     scale,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    sum_real,
    output logic [DATA_WIDTH-1:0]    sum_imag,
    output logic [DATA_WIDTH-1:0]    diff_real,
    output logic [DATA_WIDTH-1:0]    diff_imag,
    output logic                     overflow,
    input  logic                     overflow_clear,
    output logic                     busy
);

    localparam int PW = DATA_WIDTH + TWIDDLE_WIDTH;
    localparam int RW = DATA_WIDTH + 2;
    localparam int SW = DATA_WIDTH + 3;

    localparam logic signed [PW+1:0] ROUND = (PW+2)'(1) << (TWIDDLE_WIDTH - 2);
    localparam logic signed [SW-1:0] MAX_V = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_V = {{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic adv;

    logic                         s1Valid_q;
    logic                         s1Scale_q;
    logic signed [DATA_WIDTH-1:0] s1EvenRe_q;
    logic signed [DATA_WIDTH-1:0] s1EvenIm_q;
    logic signed [PW-1:0]         s1Pr1_q;
    logic signed [PW-1:0]         s1Pr2_q;
    logic signed [PW-1:0]         s1Pi1_q;
    logic signed [PW-1:0]         s1Pi2_q;

    logic                         s2Valid_q;
    logic                         s2Scale_q;
    logic signed [DATA_WIDTH-1:0] s2EvenRe_q;
    logic signed [DATA_WIDTH-1:0] s2EvenIm_q;
    logic signed [RW-1:0]         s2TRe_q;
    logic signed [RW-1:0]         s2TIm_q;

    logic                         s3Valid_q;
    logic [DATA_WIDTH-1:0]        s3SumRe_q;
    logic [DATA_WIDTH-1:0]        s3SumIm_q;
    logic [DATA_WIDTH-1:0]        s3DiffRe_q;
    logic [DATA_WIDTH-1:0]        s3DiffIm_q;
    logic                         overflow_q;

    logic signed [PW-1:0]         pr1_d;
    logic signed [PW-1:0]         pr2_d;
    logic signed [PW-1:0]         pi1_d;
    logic signed [PW-1:0]         pi2_d;
    logic signed [PW+1:0]         tReWide;
    logic signed [PW+1:0]         tImWide;
    logic signed [RW-1:0]         s2TRe_d;
    logic signed [RW-1:0]         s2TIm_d;
    logic signed [SW-1:0]         sumRe;
    logic signed [SW-1:0]         sumIm;
    logic signed [SW-1:0]         diffRe;
    logic signed [SW-1:0]         diffIm;
    logic                         anySat;
    logic                         overflow_d;

    function automatic logic signed [SW-1:0] combine(
        input logic signed [DATA_WIDTH-1:0] e,
        input logic signed [RW-1:0]         t,
        input logic                         sub,
        input logic                         sc
    );
        logic signed [SW-1:0] v;
        v = sub ? (SW'(e) - SW'(t)) : (SW'(e) + SW'(t));
        if (sc) begin
            v = (v + SW'(1)) >>> 1;
        end
        return v;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] clip(input logic signed [SW-1:0] v);
        if (v > MAX_V) begin
            return MAX_V[DATA_WIDTH-1:0];
        end else if (v < MIN_V) begin
            return MIN_V[DATA_WIDTH-1:0];
        end
        return v[DATA_WIDTH-1:0];
    endfunction

    function automatic logic isSat(input logic signed [SW-1:0] v);
        return (v > MAX_V) || (v < MIN_V);
    endfunction

    assign adv      = !s3Valid_q || out_ready;
    assign in_ready = adv;

    always_comb begin
        pr1_d = PW'($signed(odd_real)) * PW'($signed(twiddle_real));
        pr2_d = PW'($signed(odd_imag)) * PW'($signed(twiddle_imag));
        pi1_d = PW'($signed(odd_real)) * PW'($signed(twiddle_imag));
        pi2_d = PW'($signed(odd_imag)) * PW'($signed(twiddle_real));
    end

    // Round-half-up back to data scale: the twiddle is Q1.(TW-1).
    always_comb begin
        tReWide = (PW+2)'(s1Pr1_q) - (PW+2)'(s1Pr2_q);
        tImWide = (PW+2)'(s1Pi1_q) + (PW+2)'(s1Pi2_q);
        s2TRe_d = RW'((tReWide + ROUND) >>> (TWIDDLE_WIDTH - 1));
        s2TIm_d = RW'((tImWide + ROUND) >>> (TWIDDLE_WIDTH - 1));
    end

    always_comb begin
        sumRe  = combine(s2EvenRe_q, s2TRe_q, 1'b0, s2Scale_q);
        sumIm  = combine(s2EvenIm_q, s2TIm_q, 1'b0, s2Scale_q);
        diffRe = combine(s2EvenRe_q, s2TRe_q, 1'b1, s2Scale_q);
        diffIm = combine(s2EvenIm_q, s2TIm_q, 1'b1, s2Scale_q);
        anySat = isSat(sumRe) | isSat(sumIm) | isSat(diffRe) | isSat(diffIm);
    end

    // A saturation loading into S3 takes priority over a simultaneous clear.
    always_comb begin
        overflow_d = overflow_q;
        if (adv && s2Valid_q && anySat) begin
            overflow_d = 1'b1;
        end else if (overflow_clear) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1Valid_q  <= 1'b0;
            s1Scale_q  <= 1'b0;
            s1EvenRe_q <= '0;
            s1EvenIm_q <= '0;
            s1Pr1_q    <= '0;
            s1Pr2_q    <= '0;
            s1Pi1_q    <= '0;
            s1Pi2_q    <= '0;
            s2Valid_q  <= 1'b0;
            s2Scale_q  <= 1'b0;
            s2EvenRe_q <= '0;
            s2EvenIm_q <= '0;
            s2TRe_q    <= '0;
            s2TIm_q    <= '0;
            s3Valid_q  <= 1'b0;
            s3SumRe_q  <= '0;
            s3SumIm_q  <= '0;
            s3DiffRe_q <= '0;
            s3DiffIm_q <= '0;
        end else if (adv) begin
            s1Valid_q <= in_valid;
            s2Valid_q <= s1Valid_q;
            s3Valid_q <= s2Valid_q;
            if (in_valid) begin
                s1Scale_q  <= scale;
                s1EvenRe_q <= $signed(even_real);
                s1EvenIm_q <= $signed(even_imag);
                s1Pr1_q    <= pr1_d;
                s1Pr2_q    <= pr2_d;
                s1Pi1_q    <= pi1_d;
                s1Pi2_q    <= pi2_d;
            end
            if (s1Valid_q) begin
                s2Scale_q  <= s1Scale_q;
                s2EvenRe_q <= s1EvenRe_q;
                s2EvenIm_q <= s1EvenIm_q;
                s2TRe_q    <= s2TRe_d;
                s2TIm_q    <= s2TIm_d;
            end
            if (s2Valid_q) begin
                s3SumRe_q  <= clip(sumRe);
                s3SumIm_q  <= clip(sumIm);
                s3DiffRe_q <= clip(diffRe);
                s3DiffIm_q <= clip(diffIm);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign out_valid = s3Valid_q;
    assign sum_real  = s3SumRe_q;
    assign sum_imag  = s3SumIm_q;
    assign diff_real = s3DiffRe_q;
    assign diff_imag = s3DiffIm_q;
    assign overflow  = overflow_q;
    assign busy      = s1Valid_q | s2Valid_q | s3Valid_q;

endmodule

// File: tb/tb_fft_butterfly_pipe.sv
// Directed bench for fft_butterfly_pipe: arithmetic, rounding, saturation,
// sticky overflow, backpressure ordering and asynchronous mid-stream reset.
module tb_fft_butterfly_pipe;

    localparam int DW = 16;
    localparam int TW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] even_real, even_imag, odd_real, odd_imag;
    logic [TW-1:0] twiddle_real, twiddle_imag;
    logic          scale;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] sum_real, sum_imag, diff_real, diff_imag;
    logic          overflow;
    logic          overflow_clear;
    logic          busy;

    int testCount = 0;
    int failCount = 0;

    fft_butterfly_pipe #(.DATA_WIDTH(DW), .TWIDDLE_WIDTH(TW)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .even_real(even_real), .even_imag(even_imag),
        .odd_real(odd_real), .odd_imag(odd_imag),
        .twiddle_real(twiddle_real), .twiddle_imag(twiddle_imag),
        .scale(scale),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum_real(sum_real), .sum_imag(sum_imag),
        .diff_real(diff_real), .diff_imag(diff_imag),
        .overflow(overflow), .overflow_clear(overflow_clear),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int er, input int ei, input int odr, input int odi,
                                 input int twr, input int twi, input logic sc, input logic vld);
        even_real    = DW'(er);
        even_imag    = DW'(ei);
        odd_real     = DW'(odr);
        odd_imag     = DW'(odi);
        twiddle_real = TW'(twr);
        twiddle_imag = TW'(twi);
        scale        = sc;
        in_valid     = vld;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One isolated transfer, checking the three-cycle latency on the way.
    task automatic runOne(input string tag, input int er, input int ei, input int odr,
                          input int odi, input int twr, input int twi, input logic sc);
        applyStimulus(er, ei, odr, odi, twr, twi, sc, 1'b1);
        tick();
        in_valid = 1'b0;
        checkOutput({tag, "_lat1"}, out_valid, 0);
        tick();
        checkOutput({tag, "_lat2"}, out_valid, 0);
        tick();
        checkOutput({tag, "_lat3"}, out_valid, 1);
    endtask

    initial begin
        int sent;
        int recv;
        int cyc;
        logic acc;
        logic signed [31:0] prevSum;

        reset          = 1'b0;
        out_ready      = 1'b1;
        overflow_clear = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        repeat (2) tick();
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_sum_real", $signed(sum_real), 0);
        checkOutput("rst_diff_real", $signed(diff_real), 0);
        reset = 1'b1;
        tick();

        runOne("basic", 1000, 0, 500, 0, 32767, 0, 1'b0);
        checkOutput("basic_sum_re", $signed(sum_real), 1500);
        checkOutput("basic_sum_im", $signed(sum_imag), 0);
        checkOutput("basic_diff_re", $signed(diff_real), 500);
        checkOutput("basic_diff_im", $signed(diff_imag), 0);
        checkOutput("basic_ovf", overflow, 0);

        runOne("scaled", 1000, 0, 500, 0, 32767, 0, 1'b1);
        checkOutput("scaled_sum_re", $signed(sum_real), 750);
        checkOutput("scaled_diff_re", $signed(diff_real), 250);

        runOne("cplx", 0, 0, 100, 200, 0, -32768, 1'b0);
        checkOutput("cplx_sum_re", $signed(sum_real), 200);
        checkOutput("cplx_sum_im", $signed(sum_imag), -100);
        checkOutput("cplx_diff_re", $signed(diff_real), -200);
        checkOutput("cplx_diff_im", $signed(diff_imag), 100);

        runOne("sat", 32767, 0, 32767, 0, 32767, 0, 1'b0);
        checkOutput("sat_sum_re", $signed(sum_real), 32767);
        checkOutput("sat_diff_re", $signed(diff_real), 1);
        checkOutput("sat_ovf", overflow, 1);

        runOne("sticky", 1000, 0, 500, 0, 32767, 0, 1'b0);
        checkOutput("sticky_sum_re", $signed(sum_real), 1500);
        checkOutput("sticky_ovf", overflow, 1);

        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        checkOutput("clear_ovf", overflow, 0);

        runOne("satsc", 32767, 0, 32767, 0, 32767, 0, 1'b1);
        checkOutput("satsc_sum_re", $signed(sum_real), 32767);
        checkOutput("satsc_diff_re", $signed(diff_real), 1);
        checkOutput("satsc_ovf", overflow, 0);

        // Clear lands on the same edge that loads a saturating result.
        applyStimulus(32767, 0, 32767, 0, 32767, 0, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        checkOutput("setwins_valid", out_valid, 1);
        checkOutput("setwins_ovf", overflow, 1);
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        checkOutput("setwins_clear", overflow, 0);

        sent    = 0;
        recv    = 0;
        prevSum = 0;
        for (cyc = 0; recv < 8 && cyc < 40; cyc++) begin
            out_ready = (cyc >= 4 && cyc <= 7) ? 1'b0 : 1'b1;
            if (sent < 8) begin
                applyStimulus(100 * (sent + 1), sent + 1, 10 * (sent + 1), 0, 32767, 0, 1'b0, 1'b1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!out_ready) begin
                checkOutput("bp_stall_valid", out_valid, 1);
                checkOutput("bp_in_ready", in_ready, 0);
            end
            if (cyc >= 5 && cyc <= 7) begin
                checkOutput("bp_hold", $signed(sum_real), prevSum);
            end
            if (out_valid && out_ready) begin
                checkOutput("bp_sum_re", $signed(sum_real), 110 * (recv + 1));
                checkOutput("bp_sum_im", $signed(sum_imag), recv + 1);
                checkOutput("bp_diff_re", $signed(diff_real), 90 * (recv + 1));
                checkOutput("bp_diff_im", $signed(diff_imag), recv + 1);
                recv++;
            end
            acc     = in_valid && in_ready;
            prevSum = $signed(sum_real);
            @(posedge clock);
            #1;
            if (acc) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("bp_sent", sent, 8);
        checkOutput("bp_received", recv, 8);
        checkOutput("bp_drained_valid", out_valid, 0);
        checkOutput("bp_drained_busy", busy, 0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1000, 0, 500, 0, 32767, 0, 1'b0, 1'b1);
            tick();
        end
        in_valid = 1'b0;
        checkOutput("mid_pre_valid", out_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_valid", out_valid, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_sum_re", $signed(sum_real), 0);
        checkOutput("mid_rst_in_ready", in_ready, 1);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("mid_no_stale", out_valid, 0);
        end
        runOne("post", 0, 0, 100, 200, 0, -32768, 1'b0);
        checkOutput("post_sum_re", $signed(sum_real), 200);
        checkOutput("post_diff_im", $signed(diff_imag), 100);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
